// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter family.
// Holds the FSM state encoding, the index-width function and weight slicing.
package arbiter_pkg;

  typedef enum logic {
    S_ARB   = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // LSB of requester i's field in a packed weight vector.
  function automatic int unsigned wlsb(
    input int unsigned i,
    input int unsigned w
  );
    return i * w;
  endfunction

endpackage

// File: rtl/arbiter_iwrr_prog_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// Ports: request, weight_cfg, grant_ready, [grant_last] in; grant_valid, grant_idx, round_done out.
// ARB_IWRR_BURST_LOCK_EN adds grant_last.
interface arbiter_iwrr_prog_if
  import arbiter_pkg::*;
#(
  parameter int unsigned P_REQUESTER_NUM = 4,
  parameter int unsigned P_WEIGHT_W      = 4
);
  localparam int unsigned IW = idx_w(P_REQUESTER_NUM);

  logic [P_REQUESTER_NUM-1:0]            request;
  logic [P_REQUESTER_NUM*P_WEIGHT_W-1:0] weight_cfg;
  logic                                  grant_ready;
`ifdef ARB_IWRR_BURST_LOCK_EN
  logic                                  grant_last;
`endif
  logic [P_REQUESTER_NUM-1:0]            grant_valid;
  logic [IW-1:0]                         grant_idx;
  logic                                  round_done;

`ifdef ARB_IWRR_BURST_LOCK_EN
  modport master (
    output request, weight_cfg, grant_ready, grant_last,
    input  grant_valid, grant_idx, round_done
  );
  modport slave (
    input  request, weight_cfg, grant_ready, grant_last,
    output grant_valid, grant_idx, round_done
  );
`else
  modport master (
    output request, weight_cfg, grant_ready,
    input  grant_valid, grant_idx, round_done
  );
  modport slave (
    input  request, weight_cfg, grant_ready,
    output grant_valid, grant_idx, round_done
  );
`endif

endinterface

// File: rtl/arbiter_iwrr_prog_picker.sv
// Rotating first-one finder: first set bit of eligible_i starting at ptr_i, wrapping.
// Ports: eligible_i, ptr_i in; onehot_o, idx_o, found_o out.
module rr_first_picker
  import arbiter_pkg::*;
#(
  parameter int unsigned P_N = 4,
  localparam int unsigned IW = idx_w(P_N)
) (
  input  logic [P_N-1:0] eligible_i,
  input  logic [IW-1:0]  ptr_i,
  output logic [P_N-1:0] onehot_o,
  output logic [IW-1:0]  idx_o,
  output logic           found_o
);

  int unsigned p;
  int unsigned d;
  int unsigned best;

  // Pick the eligible bit with the smallest wrap distance from ptr.
  always_comb begin
    p     = 32'(ptr_i);
    d     = 0;
    best  = P_N;
    idx_o = '0;
    for (int unsigned j = 0; j < P_N; j++) begin
      d = (j >= p) ? j - p : j + P_N - p;
      if (eligible_i[j] && d < best) begin
        best  = d;
        idx_o = IW'(j);
      end
    end
    found_o  = (best != P_N);
    onehot_o = '0;
    for (int unsigned j = 0; j < P_N; j++) begin
      onehot_o[j] = found_o && (idx_o == IW'(j));
    end
  end

endmodule

// File: rtl/arbiter_iwrr_prog.sv
// Interleaved weighted round-robin arbiter with runtime weights reloaded per round.
// Ports: clk, rst (async, active-high), bus (slave modport). Option: ARB_IWRR_BURST_LOCK_EN.
module arbiter_iwrr_prog
  import arbiter_pkg::*;
#(
  parameter int unsigned P_REQUESTER_NUM = 4,
  parameter int unsigned P_WEIGHT_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  arbiter_iwrr_prog_if.slave bus
);
  localparam int unsigned N  = P_REQUESTER_NUM;
  localparam int unsigned IW = idx_w(N);

  state_t                state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [P_WEIGHT_W-1:0] credit_q [N];
  logic [P_WEIGHT_W-1:0] credit_d [N];
  logic [N-1:0]          gv_q, gv_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  done_q, done_d;

  logic [N-1:0]  elig;
  logic [N-1:0]  win_oh;
  logic [IW-1:0] win_idx;
  logic          win_found;
  logic          hs_w;

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      elig[i] = bus.request[i] & (credit_q[i] != '0);
    end
  end

  rr_first_picker #(.P_N(N)) u_pick (
    .eligible_i (elig),
    .ptr_i      (ptr_q),
    .onehot_o   (win_oh),
    .idx_o      (win_idx),
    .found_o    (win_found)
  );

`ifdef ARB_IWRR_BURST_LOCK_EN
  assign hs_w = bus.grant_ready & bus.grant_last;
`else
  assign hs_w = bus.grant_ready;
`endif

  // A handshake re-arbitrates in the same cycle so grants run back-to-back.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    gv_d     = gv_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    if (state_q == S_ARB || hs_w) begin
      if (win_found) begin
        gv_d    = win_oh;
        idx_d   = win_idx;
        ptr_d   = (win_idx == IW'(N-1)) ? '0 : win_idx + IW'(1);
        state_d = S_GRANT;
        for (int unsigned i = 0; i < N; i++) begin
          if (win_oh[i]) credit_d[i] = credit_q[i] - P_WEIGHT_W'(1);
        end
      end else begin
        gv_d    = '0;
        state_d = S_ARB;
        // Reload only from idle so a drained round ends with one empty cycle.
        if (state_q == S_ARB && |bus.request) begin
          done_d = 1'b1;
          for (int unsigned i = 0; i < N; i++) begin
            credit_d[i] = bus.weight_cfg[wlsb(i, P_WEIGHT_W) +: P_WEIGHT_W];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_ARB;
      ptr_q   <= '0;
      gv_q    <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      for (int unsigned i = 0; i < N; i++) credit_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gv_q     <= gv_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      credit_q <= credit_d;
    end
  end

  assign bus.grant_valid = gv_q;
  assign bus.grant_idx   = idx_q;
  assign bus.round_done  = done_q;

endmodule

// File: tb/tb_arbiter_iwrr_prog.sv
// Self-checking bench for arbiter_iwrr_prog against a behavioural credit model.
// Directed scenarios plus a random run; ARB_IWRR_BURST_LOCK_EN adds the burst test.
module tb_arbiter_iwrr_prog;
  localparam int N  = 4;
  localparam int WW = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arbiter_iwrr_prog_if #(.P_REQUESTER_NUM(N), .P_WEIGHT_W(WW)) bus ();

  arbiter_iwrr_prog #(.P_REQUESTER_NUM(N), .P_WEIGHT_W(WW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  int m_cr [N];
  int m_ptr;
  bit m_act;
  int m_idx;
  bit m_done;

  logic [N+IW:0] obs_v;
  logic [N+IW:0] exp_v;

  function automatic logic [N*WW-1:0] pack_w(int a, int b, int c, int d);
    return {WW'(d), WW'(c), WW'(b), WW'(a)};
  endfunction

  function automatic int wt(int i);
    int w;
    w = 0;
    for (int b = 0; b < WW; b++) if (bus.weight_cfg[i*WW+b]) w += (1 << b);
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cr[i] = 0;
    m_ptr = 0; m_act = 0; m_idx = 0; m_done = 0;
  endtask

  // Spec rules: serve next requester with credit in rotation; else reload from idle.
  task automatic model_step();
    bit rel;
    bit lst;
    int w;
    lst = 1'b1;
`ifdef ARB_IWRR_BURST_LOCK_EN
    lst = bus.grant_last;
`endif
    rel = !m_act || (bus.grant_ready && lst);
    m_done = 0;
    if (!rel) return;
    w = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (w < 0 && bus.request[j] && m_cr[j] > 0) w = j;
    end
    if (w >= 0) begin
      m_act = 1; m_idx = w; m_cr[w]--; m_ptr = (w + 1) % N;
    end else begin
      if (!m_act && |bus.request) begin
        for (int i = 0; i < N; i++) m_cr[i] = wt(i);
        m_done = 1;
      end
      m_act = 0;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    exp_v = {m_act ? (N'(1) << m_idx) : N'(0), m_act ? IW'(m_idx) : IW'(0), m_done};
    obs_v = {bus.grant_valid, m_act ? bus.grant_idx : IW'(0), bus.round_done};
  endtask

  task automatic drive_idle();
    bus.request = '0; bus.weight_cfg = '0; bus.grant_ready = 1'b0;
`ifdef ARB_IWRR_BURST_LOCK_EN
    bus.grant_last = 1'b1;
`endif
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    drive_idle();
    #3;
    checks++;
    if ({bus.grant_valid, bus.grant_idx, bus.round_done} !== '0)
      $display("FAIL reset_out got=%b want=0", {bus.grant_valid, bus.grant_idx, bus.round_done});
    if ({bus.grant_valid, bus.grant_idx, bus.round_done} !== '0) errors++;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    bus.weight_cfg = pack_w(1, 1, 1, 1);
    bus.request = 4'b1111;
    step();
    checks++;
    if (obs_v !== exp_v || bus.round_done !== 1'b1) begin
      errors++;
      $display("FAIL reset_cold got=%b want=%b", obs_v, exp_v);
    end
  endtask

  task automatic test_round_321();
    int seq[$];
    int first_c, last_c, dn;
    int exp_seq[6] = '{0, 1, 2, 0, 1, 0};
    do_reset();
    bus.weight_cfg = pack_w(3, 2, 1, 0);
    bus.request = 4'b0111;
    bus.grant_ready = 1'b1;
    dn = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL round321 c=%0d got=%b want=%b", c, obs_v, exp_v);
      end
      if (bus.round_done) dn++;
      if (dn == 1 && bus.grant_valid != 0) begin
        seq.push_back(int'(bus.grant_idx));
        if (first_c < 0) first_c = c;
        last_c = c;
      end
    end
    checks++;
    if (seq.size() != 6) begin
      errors++;
      $display("FAIL round321_len got=%0d want=6", seq.size());
    end else begin
      for (int i = 0; i < 6; i++) if (seq[i] != exp_seq[i]) begin
        errors++;
        $display("FAIL round321_seq i=%0d got=%0d want=%0d", i, seq[i], exp_seq[i]);
      end
    end
    checks++;
    if (last_c - first_c != 5) begin
      errors++;
      $display("FAIL round321_bubble got=%0d want=5", last_c - first_c);
    end
  endtask

  task automatic test_single_req();
    do_reset();
    bus.weight_cfg = pack_w(2, 2, 2, 2);
    bus.request = 4'b0100;
    bus.grant_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL single_req c=%0d got=%b want=%b", c, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_hold();
    do_reset();
    bus.weight_cfg = pack_w(1, 2, 1, 1);
    bus.request = 4'b0010;
    step();
    step();
    for (int c = 0; c < 5; c++) begin
      if (c >= 2) bus.request = '0;
      step();
      checks++;
      if (obs_v !== exp_v || bus.grant_valid !== 4'b0010) begin
        errors++;
        $display("FAIL hold c=%0d got=%b want=%b", c, obs_v, exp_v);
      end
    end
    bus.request = 4'b0010;
    bus.grant_ready = 1'b1;
    step();
    checks++;
    if (obs_v !== exp_v || bus.grant_valid !== 4'b0010) begin
      errors++;
      $display("FAIL hold_credit got=%b want=%b", obs_v, exp_v);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL hold_after c=%0d got=%b want=%b", c, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_weight_change();
    int seq[$];
    int dn;
    int exp_seq[6] = '{0, 1, 2, 0, 0, 0};
    do_reset();
    bus.weight_cfg = pack_w(1, 1, 1, 0);
    bus.request = 4'b0111;
    bus.grant_ready = 1'b1;
    dn = 0;
    for (int c = 0; c < 18; c++) begin
      if (c == 2) bus.weight_cfg = pack_w(4, 1, 1, 0);
      step();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL wchange c=%0d got=%b want=%b", c, obs_v, exp_v);
      end
      if (bus.round_done) dn++;
      if (dn == 2 && bus.grant_valid != 0) seq.push_back(int'(bus.grant_idx));
    end
    checks++;
    if (seq.size() != 6) begin
      errors++;
      $display("FAIL wchange_len got=%0d want=6", seq.size());
    end else begin
      for (int i = 0; i < 6; i++) if (seq[i] != exp_seq[i]) begin
        errors++;
        $display("FAIL wchange_seq i=%0d got=%0d want=%0d", i, seq[i], exp_seq[i]);
      end
    end
  endtask

  task automatic test_zero_weights();
    do_reset();
    bus.weight_cfg = '0;
    bus.request = 4'b1111;
    bus.grant_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (obs_v !== exp_v || bus.round_done !== 1'b1 || bus.grant_valid !== '0) begin
        errors++;
        $display("FAIL zero_w c=%0d got=%b want=%b", c, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.weight_cfg = pack_w(1, 1, 1, 0);
    bus.request = 4'b0100;
    step();
    step();
    checks++;
    if (bus.grant_valid !== 4'b0100) begin
      errors++;
      $display("FAIL areset_pre got=%b want=0100", bus.grant_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.grant_valid !== '0 || bus.grant_idx !== '0) begin
      errors++;
      $display("FAIL areset_async got=%b/%0d want=0/0", bus.grant_valid, bus.grant_idx);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (obs_v !== exp_v || (c == 0 && bus.round_done !== 1'b1)) begin
        errors++;
        $display("FAIL areset_post c=%0d got=%b want=%b", c, obs_v, exp_v);
      end
    end
  endtask

`ifdef ARB_IWRR_BURST_LOCK_EN
  task automatic test_burst();
    do_reset();
    bus.weight_cfg = pack_w(1, 1, 0, 0);
    bus.request = 4'b0011;
    bus.grant_ready = 1'b1;
    bus.grant_last = 1'b0;
    step();
    step();
    for (int b = 0; b < 4; b++) begin
      bus.grant_last = (b == 3);
      step();
      checks++;
      if (obs_v !== exp_v || bus.grant_valid !== ((b == 3) ? 4'b0010 : 4'b0001)) begin
        errors++;
        $display("FAIL burst b=%0d got=%b want=%b", b, obs_v, exp_v);
      end
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    bus.weight_cfg = pack_w(3, 1, 2, 4);
    for (int c = 0; c < 400; c++) begin
      bus.request = N'($urandom);
      bus.grant_ready = ($urandom_range(3) != 0);
`ifdef ARB_IWRR_BURST_LOCK_EN
      bus.grant_last = ($urandom_range(2) != 0);
`endif
      if ($urandom_range(9) == 0) bus.weight_cfg = (N*WW)'($urandom);
      if ($urandom_range(49) == 0) bus.weight_cfg = '0;
      step();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL random c=%0d got=%b want=%b", c, obs_v, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_321();
    test_single_req();
    test_hold();
    test_weight_change();
    test_zero_weights();
    test_async_reset();
`ifdef ARB_IWRR_BURST_LOCK_EN
    test_burst();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
